// File: rtl/led_pwm_engine.sv
// Multi-channel LED PWM driver with a single pending config slot applied at period boundaries.
// Define LED_PWM_BREATHE_EN to build the hardware breathe ramp for mode 11.
module led_pwm_engine #(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8,
  parameter int DIV      = 188,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PS_W    = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] led,
  output logic                period_strobe
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(DIV - 1);

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                boundary;

  logic                slot_full;
  logic [CH_W-1:0]     slot_ch;
  mode_e               slot_mode;
  logic [PWM_BITS-1:0] slot_duty;

  mode_e               mode  [CHANNELS];
  logic [PWM_BITS-1:0] level [CHANNELS];
  logic [CHANNELS-1:0] load_hit;
  logic [CHANNELS-1:0] led_next;

  assign tick      = (prescaler == PS_LAST);
  assign boundary  = tick && (pwm_cnt == LEVEL_MAX);
  assign cfg_ready = !slot_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler     <= '0;
      pwm_cnt       <= '0;
      period_strobe <= 1'b0;
    end else begin
      prescaler     <= tick ? '0 : prescaler + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      period_strobe <= boundary;
    end
  end

  // A transfer needs an empty slot, so it can never collide with the boundary drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= 1'b0;
      slot_ch   <= '0;
      slot_mode <= MODE_OFF;
      slot_duty <= '0;
    end else if (cfg_valid && cfg_ready) begin
      slot_full <= 1'b1;
      slot_ch   <= cfg_ch;
      slot_mode <= mode_e'(cfg_mode);
      slot_duty <= cfg_duty;
    end else if (boundary) begin
      slot_full <= 1'b0;
    end
  end

  // An out-of-range slot_ch matches no channel and is simply drained.
  always_comb begin
    load_hit = '0;
    for (int i = 0; i < CHANNELS; i++)
      load_hit[i] = boundary && slot_full && (slot_ch == CH_W'(i));
  end

`ifdef LED_PWM_BREATHE_EN
  logic [CHANNELS-1:0] dir;
  logic [PWM_BITS-1:0] ramp_level [CHANNELS];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      ramp_level[i] = dir[i] ? level[i] + 1'b1 : level[i] - 1'b1;
  end

  // Direction reverses as the ramp reaches either end, so the level never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= '1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load_hit[i]) begin
          dir[i] <= (slot_duty != LEVEL_MAX);
        end else if (boundary && mode[i] == MODE_BREATHE) begin
          if (dir[i] && ramp_level[i] == LEVEL_MAX) dir[i] <= 1'b0;
          else if (!dir[i] && ramp_level[i] == '0) dir[i] <= 1'b1;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i]  <= MODE_OFF;
        level[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load_hit[i]) begin
          mode[i]  <= slot_mode;
          level[i] <= slot_duty;
        end
`ifdef LED_PWM_BREATHE_EN
        else if (boundary && mode[i] == MODE_BREATHE) begin
          level[i] <= ramp_level[i];
        end
`endif
      end
    end
  end

  // Without the breathe build, mode 11 falls into the PWM compare path.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode[i])
        MODE_OFF: led_next[i] = 1'b0;
        MODE_ON:  led_next[i] = 1'b1;
        default:  led_next[i] = (pwm_cnt < level[i]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else        led <= led_next;
  end

endmodule

// File: tb/tb_led_pwm_engine.sv
// Self-checking bench for led_pwm_engine (CHANNELS=3, PWM_BITS=4, DIV=2: 32-clock period).
// Breathe expectations are enabled when LED_PWM_BREATHE_EN is defined.
module tb_led_pwm_engine;

  localparam int CHANNELS = 3;
  localparam int PWM_BITS = 4;
  localparam int DIV      = 2;
  localparam int PERIOD   = 1 << PWM_BITS;
  localparam int CLKS     = DIV * PERIOD;
  localparam int LMAX     = PERIOD - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_duty = '0;
  logic [2:0] led;
  logic       period_strobe;

  led_pwm_engine #(.CHANNELS(CHANNELS), .PWM_BITS(PWM_BITS), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .led(led), .period_strobe(period_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: time is the edge count k since reset release.
  int         k;
  int         m_mode  [CHANNELS];
  int         m_level [CHANNELS];
  bit         m_dir   [CHANNELS];
  bit         m_slot_full;
  int         m_slot_ch, m_slot_mode, m_slot_duty;
  logic [2:0] exp_led;
  bit         exp_strobe;
  bit         accepted;

  typedef struct {int ch; int mode; int duty; int exp_high;} vec_t;
  vec_t vecs[$];

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (edge %0d)", name, actual, expected, k);
    end
  endtask

  function automatic bit lit(input int mode, input int level, input int cnt);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return cnt < level;
  endfunction

  task automatic model_reset();
    k = 0;
    m_slot_full = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      m_mode[i] = 0; m_level[i] = 0; m_dir[i] = 1'b1;
    end
  endtask

  // Edge k: counter phase comes from k arithmetically; boundaries fall on multiples of CLKS.
  task automatic model_edge();
    int cnt_prev;
    bit boundary;
    k++;
    cnt_prev = ((k - 1) / DIV) % PERIOD;
    for (int i = 0; i < CHANNELS; i++) exp_led[i] = lit(m_mode[i], m_level[i], cnt_prev);
    boundary   = (k % CLKS) == 0;
    exp_strobe = boundary;
    accepted   = cfg_valid && !m_slot_full;
    if (boundary) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (m_slot_full && m_slot_ch == i) begin
          m_mode[i]  = m_slot_mode;
          m_level[i] = m_slot_duty;
          m_dir[i]   = (m_slot_duty != LMAX);
        end
`ifdef LED_PWM_BREATHE_EN
        else if (m_mode[i] == 3) begin
          if (m_dir[i]) begin m_level[i]++; if (m_level[i] == LMAX) m_dir[i] = 1'b0; end
          else          begin m_level[i]--; if (m_level[i] == 0)    m_dir[i] = 1'b1; end
        end
`endif
      end
      m_slot_full = 1'b0;
    end
    if (accepted) begin
      m_slot_full = 1'b1;
      m_slot_ch   = int'(cfg_ch);
      m_slot_mode = int'(cfg_mode);
      m_slot_duty = int'(cfg_duty);
    end
  endtask

  task automatic tick_and_check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output("led", int'(led), int'(exp_led));
    check_output("strobe", int'(period_strobe), int'(exp_strobe));
    check_output("cfg_ready", int'(cfg_ready), int'(!m_slot_full));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick_and_check();
  endtask

  task automatic apply_stimulus(input int ch, input int mode, input int duty);
    int guard = 0;
    cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_duty = 4'(duty);
    cfg_valid = 1'b1;
    do begin
      tick_and_check();
      guard++;
    end while (!accepted && guard < 4 * CLKS);
    cfg_valid = 1'b0;
    if (!accepted) check_output("cfg_accept_timeout", 0, 1);
  endtask

  task automatic wait_applied();
    int guard = 0;
    while (m_slot_full && guard < 4 * CLKS) begin
      tick_and_check();
      guard++;
    end
    if (m_slot_full) check_output("apply_timeout", 0, 1);
  endtask

  task automatic count_high(input int ch, output int high);
    high = 0;
    for (int i = 0; i < CLKS; i++) begin
      tick_and_check();
      high += int'(led[ch]);
    end
  endtask

  initial begin
    int first_strobe, high, k1, p, lvl;

    vecs.push_back('{0, 2, 4, 8});
    vecs.push_back('{0, 2, 0, 0});
    vecs.push_back('{0, 2, 15, 30});
    vecs.push_back('{0, 2, 1, 2});
    vecs.push_back('{1, 1, 0, 32});
    vecs.push_back('{1, 0, 7, 0});
    vecs.push_back('{2, 0, 9, 0});
    vecs.push_back('{2, 2, 9, 18});
`ifndef LED_PWM_BREATHE_EN
    vecs.push_back('{0, 3, 13, 26});
`endif

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle after reset: dark LEDs, strobe once per period starting at the first boundary.
    first_strobe = -1;
    for (int i = 0; i < 200; i++) begin
      tick_and_check();
      if (period_strobe && first_strobe < 0) first_strobe = k;
    end
    check_output("first_strobe_edge", first_strobe, CLKS);
    check_output("idle_led", int'(led), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].ch, vecs[i].mode, vecs[i].duty);
      wait_applied();
      count_high(vecs[i].ch, high);
      check_output("high_time", high, vecs[i].exp_high);
    end

    // Back-to-back writes: the second is held until the first drains at a boundary.
    apply_stimulus(1, 1, 0);
    k1 = k;
    apply_stimulus(2, 0, 0);
    check_output("held_until_boundary", k % CLKS, 1);
    check_output("held_duration_ok", int'(k - k1 >= 1), 1);
    wait_applied();
    count_high(2, high);
    check_output("ch2_off_high", high, 0);
    count_high(1, high);
    check_output("ch1_on_high", high, CLKS);

    // Transfer on the boundary edge waits a full period.
    while ((k % CLKS) != CLKS - 1) tick_and_check();
    apply_stimulus(0, 2, 6);
    check_output("bd_accept_edge", k % CLKS, 0);
    run_cycles(CLKS - 1);
    check_output("bd_held", int'(cfg_ready), 0);
    wait_applied();
    count_high(0, high);
    check_output("bd_high_time", high, 12);

    apply_stimulus(3, 1, 0);
    wait_applied();
    count_high(0, high);
    check_output("bad_ch_ch0", high, 12);
    count_high(1, high);
    check_output("bad_ch_ch1", high, CLKS);

`ifdef LED_PWM_BREATHE_EN
    // Breathe: triangle wave over 30 periods starting at 13 and rising.
    apply_stimulus(0, 3, 13);
    wait_applied();
    for (int n = 0; n < 32; n++) begin
      count_high(0, high);
      p   = (13 + n) % (2 * LMAX);
      lvl = (p <= LMAX) ? p : 2 * LMAX - p;
      check_output("breathe_high", high, 2 * lvl);
    end
`endif

    for (int n = 0; n < 40; n++) begin
      run_cycles(int'($urandom_range(0, 20)));
      apply_stimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) wait_applied();
    end
    wait_applied();
    run_cycles(2 * CLKS);

    // Asynchronous reset in the middle of a PWM high phase.
    apply_stimulus(0, 2, 12);
    wait_applied();
    run_cycles(4);
    check_output("pre_reset_high", int'(led[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("reset_led", int'(led), 0);
    check_output("reset_ready", int'(cfg_ready), 1);
    check_output("reset_strobe", int'(period_strobe), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_cycles(2 * CLKS);
    check_output("post_reset_led", int'(led), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
